// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the timed traffic-light controller:
//   - tlc_state_e : 3-bit phase encoding (code 7 is illegal and recovers to AR)
//   - LAMP_*      : 7-bit lamp patterns, one per state, bit order
//                   {HGREEN, HLEFT, HYELLOW, HRED, FLEFT, FYELLOW, FRED}
//   - lamp_decode : Moore lamp decode from a state code
// -----------------------------------------------------------------------------
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_HG  = 3'd0,
        ST_HY1 = 3'd1,
        ST_HL  = 3'd2,
        ST_HY2 = 3'd3,
        ST_FL  = 3'd4,
        ST_FY  = 3'd5,
        ST_AR  = 3'd6,
        ST_BAD = 3'd7
    } tlc_state_e;

    localparam logic [6:0] LAMP_HG  = 7'b100_0001;
    localparam logic [6:0] LAMP_HY1 = 7'b001_0001;
    localparam logic [6:0] LAMP_HL  = 7'b010_0001;
    localparam logic [6:0] LAMP_HY2 = 7'b001_0001;
    localparam logic [6:0] LAMP_FL  = 7'b000_1100;
    localparam logic [6:0] LAMP_FY  = 7'b000_1010;
    localparam logic [6:0] LAMP_AR  = 7'b000_1001;

    // The illegal code shows the all-red pattern, matching the state it recovers to.
    function automatic logic [6:0] lamp_decode(input tlc_state_e st);
        logic [6:0] lamp;
        case (st)
            ST_HG:   lamp = LAMP_HG;
            ST_HY1:  lamp = LAMP_HY1;
            ST_HL:   lamp = LAMP_HL;
            ST_HY2:  lamp = LAMP_HY2;
            ST_FL:   lamp = LAMP_FL;
            ST_FY:   lamp = LAMP_FY;
            ST_AR:   lamp = LAMP_AR;
            default: lamp = LAMP_AR;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// -----------------------------------------------------------------------------
// tlc_phase_timer
// Dwell counter for the current phase. Clears on clr_i (state change),
// otherwise increments on tick_i and saturates at all-ones.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clr_i   : clear to zero (has priority over tick_i)
//   tick_i  : timebase enable
//   count_o : current dwell count
// -----------------------------------------------------------------------------
module tlc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, then saturating increment on tick.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (tick_i && (count_q != CNT_MAX)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tlc_timed_fsm.sv
// -----------------------------------------------------------------------------
// tlc_timed_fsm
// Highway / farm-road traffic-light controller with protected left turns,
// TICK-based dwell timing, latched sensor requests and an emergency all-red.
// Ports:
//   CLOCK, RESET_N          : clock, asynchronous active-low reset
//   TICK                    : single-cycle timebase enable
//   HS, FS                  : highway-left and farm-road sensors (level)
//   EMERG                   : emergency all-red request (level)
//   HGREEN..FRED            : lamp drives, registered Moore decode of state
//   PHASE                   : current state code
//   HS_PEND, FS_PEND        : latched request flags
// -----------------------------------------------------------------------------
module tlc_timed_fsm
    import tlc_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 8,
    parameter int T_YELLOW    = 3,
    parameter int T_LEFT      = 6,
    parameter int T_FARM      = 10
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       TICK,
    input  logic       HS,
    input  logic       FS,
    input  logic       EMERG,
    output logic       HGREEN,
    output logic       HLEFT,
    output logic       HYELLOW,
    output logic       HRED,
    output logic       FLEFT,
    output logic       FYELLOW,
    output logic       FRED,
    output logic [2:0] PHASE,
    output logic       HS_PEND,
    output logic       FS_PEND
);

    // Terminal counts: a dwell of T is done when the timer shows T-1 on a TICK.
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST = CNT_W'(T_LEFT - 1);
    localparam logic [CNT_W-1:0] FARM_LAST = CNT_W'(T_FARM - 1);

    tlc_state_e       state_q;
    tlc_state_e       state_d;
    tlc_state_e       state_nxt_s;
    logic [CNT_W-1:0] timer_s;
    logic             timer_clr_s;
    logic             yel_done_s;
    logic             left_done_s;
    logic             farm_done_s;
    logic             green_ok_s;
    logic             hs_pend_q;
    logic             hs_pend_d;
    logic             fs_pend_q;
    logic             fs_pend_d;
    logic [6:0]       lamp_q;
    logic [6:0]       lamp_d;

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i   (CLOCK),
        .rst_ni  (RESET_N),
        .clr_i   (timer_clr_s),
        .tick_i  (TICK),
        .count_o (timer_s)
    );

    assign yel_done_s  = TICK && (timer_s == YEL_LAST);
    assign left_done_s = TICK && (timer_s == LEFT_LAST);
    assign farm_done_s = TICK && (timer_s == FARM_LAST);
    assign green_ok_s  = TICK && (timer_s >= GMIN_LAST);

    // Normal sequencing; green and left phases only leave via a yellow.
    always_comb begin
        state_nxt_s = state_q;
        case (state_q)
            ST_HG: begin
                if (green_ok_s && (hs_pend_q || fs_pend_q)) begin
                    state_nxt_s = ST_HY1;
                end else begin
                    state_nxt_s = ST_HG;
                end
            end
            ST_HY1: begin
                if (yel_done_s) begin
                    state_nxt_s = hs_pend_q ? ST_HL : ST_FL;
                end else begin
                    state_nxt_s = ST_HY1;
                end
            end
            ST_HL: begin
                if (left_done_s) begin
                    state_nxt_s = ST_HY2;
                end else begin
                    state_nxt_s = ST_HL;
                end
            end
            ST_HY2: begin
                if (yel_done_s) begin
                    state_nxt_s = fs_pend_q ? ST_FL : ST_HG;
                end else begin
                    state_nxt_s = ST_HY2;
                end
            end
            ST_FL: begin
                if (farm_done_s) begin
                    state_nxt_s = ST_FY;
                end else begin
                    state_nxt_s = ST_FL;
                end
            end
            ST_FY: begin
                if (yel_done_s) begin
                    state_nxt_s = ST_HG;
                end else begin
                    state_nxt_s = ST_FY;
                end
            end
            // All-red is left as soon as the emergency is gone.
            ST_AR:   state_nxt_s = ST_HG;
            default: state_nxt_s = ST_AR;
        endcase
    end

    // Emergency override, timer clear on any state change, request latches.
    always_comb begin
        state_d     = state_nxt_s;
        hs_pend_d   = hs_pend_q;
        fs_pend_d   = fs_pend_q;
        if (EMERG) begin
            state_d = ST_AR;
        end else begin
            state_d = state_nxt_s;
        end
        timer_clr_s = (state_d != state_q);
        // A fresh request on the same edge that serves the old one stays latched.
        if (HS) begin
            hs_pend_d = 1'b1;
        end else if ((state_d == ST_HL) && (state_q != ST_HL)) begin
            hs_pend_d = 1'b0;
        end else begin
            hs_pend_d = hs_pend_q;
        end
        if (FS) begin
            fs_pend_d = 1'b1;
        end else if ((state_d == ST_FL) && (state_q != ST_FL)) begin
            fs_pend_d = 1'b0;
        end else begin
            fs_pend_d = fs_pend_q;
        end
        lamp_d = lamp_decode(state_d);
    end

    // State, request flags and lamp register; lamps are decoded from the
    // next state so the registered pattern always matches the state register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_HG;
            hs_pend_q <= 1'b0;
            fs_pend_q <= 1'b0;
            lamp_q    <= LAMP_HG;
        end else begin
            state_q   <= state_d;
            hs_pend_q <= hs_pend_d;
            fs_pend_q <= fs_pend_d;
            lamp_q    <= lamp_d;
        end
    end

    assign HGREEN  = lamp_q[6];
    assign HLEFT   = lamp_q[5];
    assign HYELLOW = lamp_q[4];
    assign HRED    = lamp_q[3];
    assign FLEFT   = lamp_q[2];
    assign FYELLOW = lamp_q[1];
    assign FRED    = lamp_q[0];
    assign PHASE   = state_q;
    assign HS_PEND = hs_pend_q;
    assign FS_PEND = fs_pend_q;

endmodule

// File: doc/tlc_timed_fsm.md
TLC_TIMED_FSM -- requirements
Module: tlc_timed_fsm

Interface
REQ-001 Parameter CNT_W, 8, phase timer width in bits.
REQ-002 Parameter T_GREEN_MIN, 8, minimum highway-green dwell, in TICKs.
REQ-003 Parameter T_YELLOW, 3, every yellow dwell, in TICKs.
REQ-004 Parameter T_LEFT, 6, highway-left dwell, in TICKs.
REQ-005 Parameter T_FARM, 10, farm-left dwell, in TICKs.
REQ-006 CLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-007 RESET_N  input  1  asynchronous, active-low reset.
REQ-008 TICK  input  1  single-cycle timebase enable; timers advance only when TICK=1.
REQ-009 HS  input  1  highway left-turn sensor, level.
REQ-010 FS  input  1  farm-road sensor, level.
REQ-011 EMERG  input  1  emergency all-red request, level.
REQ-012 HGREEN, HLEFT, HYELLOW, HRED, FLEFT, FYELLOW, FRED  output  1 each  lamp drives.
REQ-013 PHASE  output  3  current state encoding.
REQ-014 HS_PEND, FS_PEND  output  1 each  latched request flags.

Function
REQ-015 States: HG(0), HY1(1), HL(2), HY2(3), FL(4), FY(5), AR(6); code 7 unused and SHALL recover to AR.
REQ-016 Lamps SHALL be Moore-decoded from the state: HG = HGREEN+FRED; HY1, HY2 = HYELLOW+FRED; HL = HLEFT+FRED; FL = HRED+FLEFT; FY = HRED+FYELLOW; AR = HRED+FRED.
REQ-017 Exactly one highway lamp and exactly one farm lamp SHALL be on in every state.
REQ-018 Timer SHALL clear to 0 on every state change and increment on TICK otherwise, saturating at 2^CNT_W-1.
REQ-019 "Dwell T done" SHALL mean TICK=1 with timer = T-1; the transition takes effect on that edge.
REQ-020 HS_PEND SHALL set on any cycle HS=1 and clear on the edge entering HL; FS_PEND likewise with FS and FL; set takes priority over clear.
REQ-021 HG->HY1 when timer >= T_GREEN_MIN-1, TICK=1 and (HS_PEND or FS_PEND); otherwise HG holds indefinitely.
REQ-022 HY1->HL on T_YELLOW done if HS_PEND, else HY1->FL.
REQ-023 HL->HY2 on T_LEFT done; HY2->FL on T_YELLOW done if FS_PEND, else HY2->HG.
REQ-024 FL->FY on T_FARM done; FY->HG on T_YELLOW done.
REQ-025 EMERG=1 SHALL force AR on the next edge from any state, overriding all other transitions; AR holds while EMERG=1.
REQ-026 AR->HG on the first edge with EMERG=0; pending flags SHALL be preserved across AR.
REQ-027 Every green or left state SHALL exit only through a yellow state, except under EMERG.
REQ-028 Parameters SHALL satisfy 1 <= T_x <= 2^CNT_W-1; a dwell of 1 lasts one TICK.

Reset
REQ-029 While RESET_N=0: state HG, timer 0, HS_PEND=FS_PEND=0, outputs HGREEN=FRED=1, all other lamps 0, PHASE=0.
REQ-030 Reset assertion mid-phase SHALL take effect immediately, without waiting for CLOCK; operation resumes in HG on the first edge after release.

Structure
REQ-031 A shared package tlc_pkg SHALL hold the state enumeration and the 7-bit lamp-pattern constants, one constant per state.
REQ-032 The dwell counter SHALL be one sub-module, tlc_phase_timer: clear, TICK-enable, saturating count, parameter CNT_W.

Verification (T_GREEN_MIN=4, T_YELLOW=2, T_LEFT=3, T_FARM=5, TICK=1 every cycle)
REQ-033 Reset, no sensors for 50 cycles -> PHASE=0, HGREEN=FRED=1 throughout.
REQ-034 HS pulse at cycle 1 -> HG for 4 cycles, HY1 2, HL 3, HY2 2, then HG; HS_PEND clears on HL entry.
REQ-035 FS and HS pulsed together -> HG 4, HY1 2, HL 3, HY2 2, FL 5, FY 2, HG.
REQ-036 EMERG asserted mid-HL for 3 cycles -> AR on the next edge for 3 cycles, then HG with timer 0; a pending FS is still served.
REQ-037 RESET_N low between clock edges during FL -> lamps go to the reset pattern at once; HG on the first edge after release.
REQ-038 Assertion on every cycle -> one highway lamp and one farm lamp on, and HGREEN and FLEFT never on together.
